// File: rtl/uart_tx_data_transfer.sv
// ---------------------------------------------------------------------------
// uart_tx_data_transfer
//
// Self-contained UART test-pattern source for board bring-up. A free-running
// period timer requests a transmission every SEND_PERIOD clocks. Each request
// sends the current Data_byte as one 8N1 frame, and the byte then increments.
//
// Optional build macro:
//   UART_TX_PARITY_EN - when defined, an even-parity bit (XOR of the 8 data
//                       bits) is inserted between the data bits and the stop
//                       bit, giving an 11-bit frame. When undefined the frame
//                       is plain 8N1 (10 bits).
//
// Ports:
//   Clk        in   1  system clock
//   Reset_n    in   1  asynchronous reset, active HIGH despite the name
//   Uart_tx    out  1  serial line, idle high, registered
//   Tx_done    out  1  one-cycle pulse when a frame completes
//   Uart_state out  1  high while a frame is being sent
//   Data_byte  out  8  byte currently being sent, or the next one to send
// ---------------------------------------------------------------------------
module uart_tx_data_transfer #(
  parameter int         CLK_FREQ    = 50_000_000,
  parameter int         BAUD        = 115200,
  parameter int         SEND_PERIOD = 500_000,
  parameter logic [7:0] START_BYTE  = 8'h00
) (
  input  logic       Clk,
  input  logic       Reset_n,
  output logic       Uart_tx,
  output logic       Tx_done,
  output logic       Uart_state,
  output logic [7:0] Data_byte
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int BAUD_W   = $clog2(BAUD_DIV + 1);
  localparam int TIMER_W  = $clog2(SEND_PERIOD + 1);

  localparam logic [BAUD_W-1:0]  BAUD_LAST  = BAUD_W'(BAUD_DIV - 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SEND_PERIOD - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd4,
`endif
    ST_STOP   = 3'd3
  } state_t;

  state_t state_reg, state_next;

  logic [TIMER_W-1:0] timer_reg;
  logic [BAUD_W-1:0]  baud_cnt_reg, baud_cnt_next;
  logic [2:0]         bit_idx_reg, bit_idx_next;
  logic [7:0]         shift_reg, shift_next;
  logic [7:0]         data_reg, data_next;
  logic               pending_reg, pending_next;
  logic               tx_reg, tx_next;
  logic               done_reg, done_next;
  logic               busy_reg, busy_next;
`ifdef UART_TX_PARITY_EN
  logic               parity_reg, parity_next;
`endif

  logic req_pulse;   // period timer hit its last count this cycle
  logic start_req;   // fresh or held-over request
  logic bit_end;     // last clock of the current bit
  logic frame_end;   // last clock of the stop bit

  assign req_pulse = (timer_reg == TIMER_LAST);
  assign start_req = req_pulse | pending_reg;
  assign bit_end   = (baud_cnt_reg == BAUD_LAST);
  assign frame_end = (state_reg == ST_STOP) && bit_end;

  // Period timer: free-running 0..SEND_PERIOD-1 from reset release.
  always_ff @(posedge Clk or posedge Reset_n) begin
    if (Reset_n) begin
      timer_reg <= '0;
    end else if (req_pulse) begin
      timer_reg <= '0;
    end else begin
      timer_reg <= timer_reg + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge Clk or posedge Reset_n) begin
    if (Reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start_req) state_next = ST_START;
      ST_START: if (bit_end)   state_next = ST_DATA;
      ST_DATA: begin
        if (bit_end && (bit_idx_reg == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          state_next = ST_PARITY;
`else
          state_next = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (bit_end) state_next = ST_STOP;
`endif
      ST_STOP:  if (bit_end)   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // FSM outputs. The line level is derived from the current state and then
  // registered, so the line trails the state by one clock and never glitches.
  always_comb begin
    tx_next   = 1'b1;
    done_next = frame_end;
    busy_next = (state_next != ST_IDLE);
    case (state_reg)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = shift_reg[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_next = parity_reg;
`endif
      default:   tx_next = 1'b1;
    endcase
  end

  // Datapath next values: bit timing, shifter, byte counter, request hold.
  always_comb begin
    baud_cnt_next = baud_cnt_reg + 1'b1;
    bit_idx_next  = bit_idx_reg;
    shift_next    = shift_reg;
    data_next     = data_reg;
`ifdef UART_TX_PARITY_EN
    parity_next   = parity_reg;
`endif
    // A request arriving while busy is remembered once; any further requests
    // before the transmitter goes idle collapse into the same pending flag.
    pending_next  = (state_reg == ST_IDLE) ? 1'b0 : (pending_reg | req_pulse);

    if ((state_reg == ST_IDLE) || bit_end) begin
      baud_cnt_next = '0;
    end

    if (state_reg == ST_IDLE) begin
      bit_idx_next = 3'd0;
      if (start_req) begin
        shift_next  = data_reg;
`ifdef UART_TX_PARITY_EN
        parity_next = ^data_reg;
`endif
      end
    end else if ((state_reg == ST_DATA) && bit_end) begin
      bit_idx_next = bit_idx_reg + 3'd1;
      shift_next   = {1'b0, shift_reg[7:1]};
    end

    if (frame_end) begin
      data_next = data_reg + 8'd1;
    end
  end

  always_ff @(posedge Clk or posedge Reset_n) begin
    if (Reset_n) begin
      baud_cnt_reg <= '0;
      bit_idx_reg  <= 3'd0;
      shift_reg    <= 8'h00;
      data_reg     <= START_BYTE;
      pending_reg  <= 1'b0;
      tx_reg       <= 1'b1;
      done_reg     <= 1'b0;
      busy_reg     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      baud_cnt_reg <= baud_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      shift_reg    <= shift_next;
      data_reg     <= data_next;
      pending_reg  <= pending_next;
      tx_reg       <= tx_next;
      done_reg     <= done_next;
      busy_reg     <= busy_next;
`ifdef UART_TX_PARITY_EN
      parity_reg   <= parity_next;
`endif
    end
  end

  assign Uart_tx    = tx_reg;
  assign Tx_done    = done_reg;
  assign Uart_state = busy_reg;
  assign Data_byte  = data_reg;

endmodule

// File: tb/tb_uart_tx_data_transfer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_data_transfer
//
// Directed bench for uart_tx_data_transfer using a scaled clock/baud ratio
// (BAUD_DIV = 10) so several frames fit in a short run. Three instances share
// clock and reset:
//   A: SEND_PERIOD 10000, START_BYTE 8'h63  (frame contents, spacing, reset)
//   B: SEND_PERIOD 10000, START_BYTE 8'hFF  (byte wrap-around)
//   C: SEND_PERIOD 200,   START_BYTE 8'h00  (first frame of zeros)
// Cycle numbers count rising edges after reset release.
// ---------------------------------------------------------------------------
module tb_uart_tx_data_transfer;

  localparam int DIV  = 10;
  localparam int SP   = 10000;
  localparam int SPC  = 200;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
  // {stop, parity, data LSB-first, start}
  localparam logic [10:0] FRAME_63 = 11'b100_1100_0110;
  localparam logic [10:0] FRAME_64 = 11'b110_1100_1000;
`else
  localparam int FB = 10;
  localparam logic [10:0] FRAME_63 = 11'b010_1100_0110;
  localparam logic [10:0] FRAME_64 = 11'b010_1100_1000;
`endif
  localparam int FLEN = FB * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_a, done_a, state_a;
  logic       tx_b, done_b, state_b;
  logic       tx_c, done_c, state_c;
  logic [7:0] data_a, data_b, data_c;

  int checks = 0;
  int errors = 0;
  int now    = 0;
  int done_cnt_a = 0;
  logic [10:0] frame_bits;

  always #5 clk = ~clk;

  uart_tx_data_transfer #(.CLK_FREQ(1_000_000), .BAUD(100_000),
                          .SEND_PERIOD(SP), .START_BYTE(8'h63)) dut_a (
    .Clk(clk), .Reset_n(rst), .Uart_tx(tx_a), .Tx_done(done_a),
    .Uart_state(state_a), .Data_byte(data_a));

  uart_tx_data_transfer #(.CLK_FREQ(1_000_000), .BAUD(100_000),
                          .SEND_PERIOD(SP), .START_BYTE(8'hFF)) dut_b (
    .Clk(clk), .Reset_n(rst), .Uart_tx(tx_b), .Tx_done(done_b),
    .Uart_state(state_b), .Data_byte(data_b));

  uart_tx_data_transfer #(.CLK_FREQ(1_000_000), .BAUD(100_000),
                          .SEND_PERIOD(SPC), .START_BYTE(8'h00)) dut_c (
    .Clk(clk), .Reset_n(rst), .Uart_tx(tx_c), .Tx_done(done_c),
    .Uart_state(state_c), .Data_byte(data_c));

  always @(posedge clk) begin
    if (!rst && done_a) done_cnt_a++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after rising edge number c.
  task automatic wait_until(input int c);
    while (now < c) begin
      @(posedge clk);
      now++;
    end
    #1;
  endtask

  initial begin
    // Reset held 200 ns.
    rst = 1'b1;
    #100;
    check("rst_tx_a",    32'(tx_a),    32'd1);
    check("rst_done_a",  32'(done_a),  32'd0);
    check("rst_state_a", 32'(state_a), 32'd0);
    check("rst_data_a",  32'(data_a),  32'h63);
    check("rst_data_c",  32'(data_c),  32'h00);
    #100;
    rst = 1'b0;
    now = 0;

    // Instance C: first frame of 8'h00.
    wait_until(SPC - 1);
    check("c_pre_tx",    32'(tx_c),    32'd1);
    check("c_pre_state", 32'(state_c), 32'd0);
    wait_until(SPC);
    check("c_req_state", 32'(state_c), 32'd1);
    check("c_req_tx",    32'(tx_c),    32'd1);
    wait_until(SPC + 1);
    check("c_fall_tx",   32'(tx_c),    32'd0);
    for (int k = 0; k < FB; k++) begin
      wait_until(SPC + 1 + k * DIV + DIV / 2);
      check($sformatf("c_bit%0d", k), 32'(tx_c), (k == FB - 1) ? 32'd1 : 32'd0);
    end
    wait_until(SPC + FLEN);
    check("c_done",      32'(done_c),  32'd1);
    check("c_done_st",   32'(state_c), 32'd0);
    check("c_data_inc",  32'(data_c),  32'h01);
    wait_until(SPC + FLEN + 1);
    check("c_done_end",  32'(done_c),  32'd0);

    // Instance A: first frame of 8'h63; B wraps 8'hFF.
    wait_until(SP - 1);
    check("a_pre_tx",    32'(tx_a),    32'd1);
    check("a_pre_state", 32'(state_a), 32'd0);
    check("a_pre_data",  32'(data_a),  32'h63);
    check("b_pre_data",  32'(data_b),  32'hFF);
    check("a_pre_dcnt",  32'(done_cnt_a), 32'd0);
    wait_until(SP);
    check("a_req_state", 32'(state_a), 32'd1);
    check("a_req_tx",    32'(tx_a),    32'd1);
    wait_until(SP + 1);
    check("a_fall_tx",   32'(tx_a),    32'd0);
    frame_bits = FRAME_63;
    for (int k = 0; k < FB; k++) begin
      wait_until(SP + 1 + k * DIV + DIV / 2);
      check($sformatf("a63_bit%0d", k), 32'(tx_a), 32'(frame_bits[k]));
    end
    wait_until(SP + FLEN - 1);
    check("a_last_done",  32'(done_a),  32'd0);
    check("a_last_state", 32'(state_a), 32'd1);
    check("a_last_data",  32'(data_a),  32'h63);
    wait_until(SP + FLEN);
    check("a_done",       32'(done_a),  32'd1);
    check("a_done_state", 32'(state_a), 32'd0);
    check("a_data_inc",   32'(data_a),  32'h64);
    check("b_done",       32'(done_b),  32'd1);
    check("b_data_wrap",  32'(data_b),  32'h00);
    wait_until(SP + FLEN + 1);
    check("a_done_end",   32'(done_a),  32'd0);
    check("a_idle_tx",    32'(tx_a),    32'd1);

    // Second frame of A, 8'h64, starts SP clocks after the first.
    wait_until(2 * SP);
    check("a2_pre_tx",   32'(tx_a),    32'd1);
    check("a_dcnt_one",  32'(done_cnt_a), 32'd1);
    wait_until(2 * SP + 1);
    check("a2_fall_tx",  32'(tx_a),    32'd0);
    frame_bits = FRAME_64;
    for (int k = 0; k < 5; k++) begin
      wait_until(2 * SP + 1 + k * DIV + DIV / 2);
      check($sformatf("a64_bit%0d", k), 32'(tx_a), 32'(frame_bits[k]));
    end
    check("a2_busy",     32'(state_a), 32'd1);

    // Reset in the middle of a data bit that is low.
    rst = 1'b1;
    #1;
    check("ar_tx",    32'(tx_a),    32'd1);
    check("ar_state", 32'(state_a), 32'd0);
    check("ar_done",  32'(done_a),  32'd0);
    check("ar_data",  32'(data_a),  32'h63);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    now = 0;

    wait_until(SP - 1);
    check("rr_pre_state", 32'(state_a), 32'd0);
    wait_until(SP);
    check("rr_req_state", 32'(state_a), 32'd1);
    wait_until(SP + 1);
    check("rr_fall_tx",   32'(tx_a),    32'd0);
    frame_bits = FRAME_63;
    wait_until(SP + 1 + DIV + DIV / 2);
    check("rr_bit1",      32'(tx_a),    32'(frame_bits[1]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
